lowspeed_host: RTL and testbench
================================

LOWSPEED_HOST -- requirements
Module: lowspeed_host

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 24'd1000000, response-byte timeout in clocks; 0 disables the timeout.
REQ-002 clock  input  1  system clock; all logic on posedge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 cmd_opcode_i  input  8  opcode; bits [7:6] give the argument byte count (0-3).
REQ-005 cmd_args_i  input  24  arguments, low-aligned; the count from opcode[7:6] selects cmd_args_i[8n-1:0].
REQ-006 cmd_resp_count_i  input  2  expected response bytes (0-3).
REQ-007 cmd_valid_i / cmd_ready_o  input/output  1/1  command handshake; transfer when both are high.
REQ-008 tx_data_o / tx_valid_o / tx_ready_i  output/output/input  8/1/1  byte stream toward the command processor.
REQ-009 rx_data_i / rx_valid_i / rx_ready_o  input/input/output  8/1/1  byte stream from the command processor.
REQ-010 resp_data_o / resp_count_o / resp_timeout_o  output/output/output  24/2/1  completed response.
REQ-011 resp_valid_o / resp_ready_i  output/input  1/1  response handshake.
REQ-012 errors_clear_i  input  1  single-cycle pulse that clears the sticky error flags.
REQ-013 error_timeout_o / error_unexpected_rx_o  output/output  1/1  sticky error flags.

Function
REQ-014 The state machine SHALL have exactly these states: IDLE, OPCODE, ARGS, RESP, DONE; any other encoding SHALL go to IDLE on the next clock.
REQ-015 IDLE: cmd_ready_o=1; on cmd_valid_i, latch opcode, args and resp count, then go to OPCODE.
REQ-016 OPCODE: tx_valid_o=1 and tx_data_o=opcode; on tx_ready_i, go to ARGS if opcode[7:6]!=0, otherwise go to RESP.
REQ-017 ARGS: send n=opcode[7:6] bytes most-significant first (args[8n-1:8n-8] first, args[7:0] last), one byte per tx handshake; after the last byte, go to RESP.
REQ-018 tx_data_o SHALL hold stable while tx_valid_o=1 and tx_ready_i=0; tx_valid_o=0 outside OPCODE and ARGS.
REQ-019 RESP with resp count 0: go to DONE on the next clock without consuming rx bytes.
REQ-020 RESP: rx_ready_o=1; the k-th accepted byte (k=0,1,2) SHALL be written to resp_data[8k+7:8k]; after resp-count bytes, go to DONE.
REQ-021 The unused upper resp_data bits SHALL read 0.
REQ-022 Timeout counter (24-bit): cleared on entry to RESP and on each accepted rx byte; increments otherwise.
REQ-023 When the timeout counter equals TIMEOUT_CYCLES (nonzero): go to DONE with resp_timeout_o=1 and resp_count_o=bytes received so far; set error_timeout_o.
REQ-024 DONE: resp_valid_o=1 with data/count/timeout held stable; on resp_ready_i, go to IDLE.
REQ-025 rx_ready_o=1 in IDLE, OPCODE and ARGS; any rx byte accepted there is dropped and sets error_unexpected_rx_o.
REQ-026 rx_ready_o=0 in DONE.
REQ-027 A timeout reached in the same cycle an rx byte is accepted: the byte wins and the counter clears.
REQ-028 errors_clear_i coinciding with a new error event: the set wins.
REQ-029 Command-to-first-tx latency SHALL be 1 clock (tx_valid_o high the cycle after the cmd handshake).
REQ-030 Response-to-resp_valid latency SHALL be 1 clock after the last rx handshake.

Reset
REQ-031 When reset=0 at a clock edge: state=IDLE, cmd_ready_o=1, tx_valid_o=0, resp_valid_o=0, resp_data_o=0, resp_count_o=0, resp_timeout_o=0, error flags=0, counter=0.
REQ-032 Reset asserted mid-command SHALL abandon the command immediately; no partial response is produced.
REQ-033 Power-up initial values SHALL equal the reset values.

Verification
REQ-034 Opcode 8'h83, args 24'h00BEEF, resp count 2, tx_ready_i=1, responder returns BE then EF -> tx 83,BE,EF; resp_data_o=24'h00EFBE, resp_count_o=2, resp_timeout_o=0.
REQ-035 Opcode 8'h01, resp count 0 -> tx 01 only; resp_valid_o asserted 2 clocks after the tx handshake with resp_count_o=0.
REQ-036 Opcode 8'hC4, args 24'h123456, tx_ready_i toggling 1/0 -> tx 12,34,56 in order, each byte stable while stalled.
REQ-037 TIMEOUT_CYCLES=16, resp count 3, only one rx byte 8'hAA -> DONE with resp_data_o=24'h0000AA, resp_count_o=1, resp_timeout_o=1, error_timeout_o=1.
REQ-038 rx byte 8'h55 injected in IDLE -> error_unexpected_rx_o=1; an errors_clear_i pulse then clears it.
REQ-039 reset=0 during ARGS of opcode 8'hC4 -> next cycle IDLE, tx_valid_o=0; a following 8'h42 command completes normally.

Source files
------------

// File: rtl/lowspeed_host_if.sv
// Bus bundle for lowspeed_host: command, tx/rx byte streams, response and error flags.
// The master modport is the host side; slave is the command/response environment.
interface lowspeed_host_if;
  logic [7:0]  cmd_opcode_i;
  logic [23:0] cmd_args_i;
  logic [1:0]  cmd_resp_count_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;

  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;

  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;

  logic [23:0] resp_data_o;
  logic [1:0]  resp_count_o;
  logic        resp_timeout_o;
  logic        resp_valid_o;
  logic        resp_ready_i;

  logic        errors_clear_i;
  logic        error_timeout_o;
  logic        error_unexpected_rx_o;

  modport master (
    input  cmd_opcode_i, cmd_args_i, cmd_resp_count_i, cmd_valid_i,
    output cmd_ready_o,
    output tx_data_o, tx_valid_o,
    input  tx_ready_i,
    input  rx_data_i, rx_valid_i,
    output rx_ready_o,
    output resp_data_o, resp_count_o, resp_timeout_o, resp_valid_o,
    input  resp_ready_i,
    input  errors_clear_i,
    output error_timeout_o, error_unexpected_rx_o
  );

  modport slave (
    output cmd_opcode_i, cmd_args_i, cmd_resp_count_i, cmd_valid_i,
    input  cmd_ready_o,
    input  tx_data_o, tx_valid_o,
    output tx_ready_i,
    output rx_data_i, rx_valid_i,
    input  rx_ready_o,
    input  resp_data_o, resp_count_o, resp_timeout_o, resp_valid_o,
    output resp_ready_i,
    output errors_clear_i,
    input  error_timeout_o, error_unexpected_rx_o
  );
endinterface

// File: rtl/lowspeed_host.sv
// Low-speed command host: sends opcode + 0..3 argument bytes, collects 0..3 response
// bytes with a per-byte timeout, then presents the response until accepted.
module lowspeed_host #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input logic            clock,
  input logic            reset,
  lowspeed_host_if.master bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StOpcode = 3'd1,
    StArgs   = 3'd2,
    StResp   = 3'd3,
    StDone   = 3'd4
  } state_t;

  state_t      state, state_next;
  logic [7:0]  opcode, opcode_next;
  logic [23:0] args, args_next;
  logic [1:0]  resp_expected, resp_expected_next;
  logic [1:0]  arg_left, arg_left_next;
  logic [1:0]  rx_count, rx_count_next;
  logic [23:0] resp_data, resp_data_next;
  logic [1:0]  resp_count, resp_count_next;
  logic        resp_timeout, resp_timeout_next;
  logic [23:0] timer, timer_next;
  logic        err_timeout, err_timeout_next;
  logic        err_unexpected, err_unexpected_next;
  logic        timeout_set, unexpected_set;
  logic [23:0] args_shifted;

  // Current argument byte: arg_left counts down, so the most significant byte goes first.
  assign args_shifted = args >> {arg_left - 2'd1, 3'b000};

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= StIdle;
    end else begin
      state <= state_next;
    end
  end

  // Datapath, response and sticky error registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      opcode         <= 8'd0;
      args           <= 24'd0;
      resp_expected  <= 2'd0;
      arg_left       <= 2'd0;
      rx_count       <= 2'd0;
      resp_data      <= 24'd0;
      resp_count     <= 2'd0;
      resp_timeout   <= 1'b0;
      timer          <= 24'd0;
      err_timeout    <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      opcode         <= opcode_next;
      args           <= args_next;
      resp_expected  <= resp_expected_next;
      arg_left       <= arg_left_next;
      rx_count       <= rx_count_next;
      resp_data      <= resp_data_next;
      resp_count     <= resp_count_next;
      resp_timeout   <= resp_timeout_next;
      timer          <= timer_next;
      err_timeout    <= err_timeout_next;
      err_unexpected <= err_unexpected_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next         = state;
    opcode_next        = opcode;
    args_next          = args;
    resp_expected_next = resp_expected;
    arg_left_next      = arg_left;
    rx_count_next      = rx_count;
    resp_data_next     = resp_data;
    resp_count_next    = resp_count;
    resp_timeout_next  = resp_timeout;
    timer_next         = timer;
    timeout_set        = 1'b0;
    unexpected_set     = 1'b0;
    bus.cmd_ready_o    = 1'b0;
    bus.tx_valid_o     = 1'b0;
    bus.tx_data_o      = opcode;
    bus.rx_ready_o     = 1'b0;

    case (state)
      StIdle: begin
        bus.cmd_ready_o = 1'b1;
        bus.rx_ready_o  = 1'b1;
        unexpected_set  = bus.rx_valid_i;
        if (bus.cmd_valid_i) begin
          opcode_next        = bus.cmd_opcode_i;
          args_next          = bus.cmd_args_i;
          resp_expected_next = bus.cmd_resp_count_i;
          arg_left_next      = bus.cmd_opcode_i[7:6];
          rx_count_next      = 2'd0;
          resp_data_next     = 24'd0;
          resp_count_next    = 2'd0;
          resp_timeout_next  = 1'b0;
          state_next         = StOpcode;
        end
      end
      StOpcode: begin
        bus.tx_valid_o = 1'b1;
        bus.tx_data_o  = opcode;
        bus.rx_ready_o = 1'b1;
        unexpected_set = bus.rx_valid_i;
        if (bus.tx_ready_i) begin
          timer_next = 24'd0;
          state_next = (opcode[7:6] != 2'd0) ? StArgs : StResp;
        end
      end
      StArgs: begin
        bus.tx_valid_o = 1'b1;
        bus.tx_data_o  = args_shifted[7:0];
        bus.rx_ready_o = 1'b1;
        unexpected_set = bus.rx_valid_i;
        if (bus.tx_ready_i) begin
          arg_left_next = arg_left - 2'd1;
          timer_next    = 24'd0;
          if (arg_left == 2'd1) begin
            state_next = StResp;
          end
        end
      end
      StResp: begin
        if (resp_expected == 2'd0) begin
          state_next = StDone;
        end else begin
          bus.rx_ready_o = 1'b1;
          // An accepted byte takes priority over a coincident timeout.
          if (bus.rx_valid_i) begin
            resp_data_next  = resp_data | ({16'd0, bus.rx_data_i} << {rx_count, 3'b000});
            rx_count_next   = rx_count + 2'd1;
            resp_count_next = rx_count + 2'd1;
            timer_next      = 24'd0;
            if (rx_count + 2'd1 == resp_expected) begin
              state_next = StDone;
            end
          end else if ((TIMEOUT_CYCLES != 24'd0) && (timer == TIMEOUT_CYCLES)) begin
            resp_timeout_next = 1'b1;
            timeout_set       = 1'b1;
            state_next        = StDone;
          end else begin
            timer_next = timer + 24'd1;
          end
        end
      end
      StDone: begin
        if (bus.resp_ready_i) begin
          state_next = StIdle;
        end
      end
      default: begin
        state_next = StIdle;
      end
    endcase

    // A new error event wins over a coincident clear.
    err_timeout_next    = (err_timeout & ~bus.errors_clear_i) | timeout_set;
    err_unexpected_next = (err_unexpected & ~bus.errors_clear_i) | unexpected_set;
  end

  assign bus.resp_valid_o          = (state == StDone);
  assign bus.resp_data_o           = resp_data;
  assign bus.resp_count_o          = resp_count;
  assign bus.resp_timeout_o        = resp_timeout;
  assign bus.error_timeout_o       = err_timeout;
  assign bus.error_unexpected_rx_o = err_unexpected;

endmodule

// File: tb/tb_lowspeed_host.sv
// Directed bench for lowspeed_host: table of command/response vectors plus hand-written
// sequences for unexpected rx, error clearing and mid-command reset.
module tb_lowspeed_host;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  lowspeed_host_if bus ();

  lowspeed_host #(
    .TIMEOUT_CYCLES(24'd16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  opcode;
    logic [23:0] args;
    logic [1:0]  rcnt;
    int          rx_n;
    logic [23:0] rx;      // byte k at [8k+7:8k]
    logic        stall;
    int          tx_n;
    logic [31:0] tx;      // byte i at [8i+7:8i], first sent at [7:0]
    int          wait_n;  // clocks from last rx (or tx) step to resp_valid
    logic [23:0] data;
    logic [1:0]  cnt;
    logic        to;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] opcode, input logic [23:0] args,
                              input logic [1:0] rcnt, input int rx_n, input logic [23:0] rx,
                              input logic stall, input int tx_n, input logic [31:0] tx,
                              input int wait_n, input logic [23:0] data, input logic [1:0] cnt,
                              input logic to);
    vec_t v;
    v.opcode = opcode; v.args = args; v.rcnt = rcnt; v.rx_n = rx_n; v.rx = rx;
    v.stall = stall; v.tx_n = tx_n; v.tx = tx; v.wait_n = wait_n;
    v.data = data; v.cnt = cnt; v.to = to;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int idx;
    int cyc;
    logic held_v;
    logic [7:0] held;
    bus.cmd_opcode_i     = v.opcode;
    bus.cmd_args_i       = v.args;
    bus.cmd_resp_count_i = v.rcnt;
    bus.cmd_valid_i      = 1'b1;
    check($sformatf("v%0d cmd_ready", id), 32'(bus.cmd_ready_o), 32'd1);
    tick;
    bus.cmd_valid_i = 1'b0;
    check($sformatf("v%0d tx latency", id), 32'(bus.tx_valid_o), 32'd1);

    idx = 0;
    cyc = 0;
    held_v = 1'b0;
    held = 8'd0;
    bus.tx_ready_i = !v.stall;
    while (idx < v.tx_n && cyc < 100) begin
      if (held_v) check($sformatf("v%0d tx stable %0d", id, idx), 32'(bus.tx_data_o), 32'(held));
      held_v = 1'b0;
      if (bus.tx_valid_o) begin
        if (bus.tx_ready_i) begin
          check($sformatf("v%0d tx byte %0d", id, idx), 32'(bus.tx_data_o), 32'(v.tx[8*idx+:8]));
          idx++;
        end else begin
          held = bus.tx_data_o;
          held_v = 1'b1;
        end
      end
      tick;
      cyc++;
      if (v.stall) bus.tx_ready_i = !bus.tx_ready_i;
    end
    bus.tx_ready_i = 1'b0;
    check($sformatf("v%0d tx count", id), 32'(idx), 32'(v.tx_n));
    check($sformatf("v%0d tx idle", id), 32'(bus.tx_valid_o), 32'd0);

    for (int k = 0; k < v.rx_n; k++) begin
      bus.rx_data_i  = v.rx[8*k+:8];
      bus.rx_valid_i = 1'b1;
      check($sformatf("v%0d rx_ready %0d", id, k), 32'(bus.rx_ready_o), 32'd1);
      tick;
    end
    bus.rx_valid_i = 1'b0;

    cyc = 0;
    while (!bus.resp_valid_o && cyc < 100) begin
      tick;
      cyc++;
    end
    check($sformatf("v%0d resp wait", id), 32'(cyc), 32'(v.wait_n));
    check($sformatf("v%0d resp_data", id), 32'(bus.resp_data_o), 32'(v.data));
    check($sformatf("v%0d resp_count", id), 32'(bus.resp_count_o), 32'(v.cnt));
    check($sformatf("v%0d resp_timeout", id), 32'(bus.resp_timeout_o), 32'(v.to));
    check($sformatf("v%0d rx_ready done", id), 32'(bus.rx_ready_o), 32'd0);
    bus.resp_ready_i = 1'b1;
    tick;
    bus.resp_ready_i = 1'b0;
    check($sformatf("v%0d resp released", id), 32'(bus.resp_valid_o), 32'd0);
    check($sformatf("v%0d back idle", id), 32'(bus.cmd_ready_o), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cmd_opcode_i     = 8'd0;
    bus.cmd_args_i       = 24'd0;
    bus.cmd_resp_count_i = 2'd0;
    bus.cmd_valid_i      = 1'b0;
    bus.tx_ready_i       = 1'b0;
    bus.rx_data_i        = 8'd0;
    bus.rx_valid_i       = 1'b0;
    bus.resp_ready_i     = 1'b0;
    bus.errors_clear_i   = 1'b0;

    //        opcode  args        rcnt rx_n rx          stall tx_n tx             wait data        cnt to
    vecs[0] = mk(8'h83, 24'h00BEEF, 2'd2, 2, 24'h00EFBE, 1'b0, 3, 32'h00EFBE83, 0,  24'h00EFBE, 2'd2, 1'b0);
    vecs[1] = mk(8'h01, 24'h000000, 2'd0, 0, 24'h000000, 1'b0, 1, 32'h00000001, 1,  24'h000000, 2'd0, 1'b0);
    vecs[2] = mk(8'hC4, 24'h123456, 2'd0, 0, 24'h000000, 1'b1, 4, 32'h563412C4, 1,  24'h000000, 2'd0, 1'b0);
    vecs[3] = mk(8'h10, 24'h000000, 2'd3, 1, 24'h0000AA, 1'b0, 1, 32'h00000010, 17, 24'h0000AA, 2'd1, 1'b1);
    vecs[4] = mk(8'h42, 24'hFFFF9A, 2'd3, 3, 24'h332211, 1'b0, 2, 32'h00009A42, 0,  24'h332211, 2'd3, 1'b0);
    vecs[5] = mk(8'h81, 24'hABCDEF, 2'd1, 1, 24'h00005A, 1'b0, 3, 32'h00EFCD81, 0,  24'h00005A, 2'd1, 1'b0);

    // Reset state.
    tick;
    tick;
    reset = 1'b1;
    #1;
    check("rst cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    check("rst tx_valid", 32'(bus.tx_valid_o), 32'd0);
    check("rst resp_valid", 32'(bus.resp_valid_o), 32'd0);
    check("rst resp_data", 32'(bus.resp_data_o), 32'd0);
    check("rst resp_count", 32'(bus.resp_count_o), 32'd0);
    check("rst resp_timeout", 32'(bus.resp_timeout_o), 32'd0);
    check("rst err_timeout", 32'(bus.error_timeout_o), 32'd0);
    check("rst err_unexp", 32'(bus.error_unexpected_rx_o), 32'd0);
    check("rst rx_ready", 32'(bus.rx_ready_o), 32'd1);

    // Table-driven command/response vectors; sticky flags checked then cleared each time.
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], i);
      check($sformatf("v%0d err_timeout", i), 32'(bus.error_timeout_o), 32'(vecs[i].to));
      check($sformatf("v%0d err_unexp", i), 32'(bus.error_unexpected_rx_o), 32'd0);
      bus.errors_clear_i = 1'b1;
      tick;
      bus.errors_clear_i = 1'b0;
      check($sformatf("v%0d err cleared", i), 32'(bus.error_timeout_o), 32'd0);
    end

    // Unexpected rx byte in IDLE sets the sticky flag; a clear pulse removes it.
    bus.rx_data_i  = 8'h55;
    bus.rx_valid_i = 1'b1;
    tick;
    bus.rx_valid_i = 1'b0;
    check("unexp set", 32'(bus.error_unexpected_rx_o), 32'd1);
    check("unexp no resp", 32'(bus.resp_valid_o), 32'd0);
    check("unexp still idle", 32'(bus.cmd_ready_o), 32'd1);
    bus.errors_clear_i = 1'b1;
    tick;
    bus.errors_clear_i = 1'b0;
    check("unexp cleared", 32'(bus.error_unexpected_rx_o), 32'd0);

    // Set wins over a coincident clear.
    bus.rx_valid_i     = 1'b1;
    bus.errors_clear_i = 1'b1;
    tick;
    bus.rx_valid_i     = 1'b0;
    bus.errors_clear_i = 1'b0;
    check("set beats clear", 32'(bus.error_unexpected_rx_o), 32'd1);
    bus.errors_clear_i = 1'b1;
    tick;
    bus.errors_clear_i = 1'b0;
    check("clear after set", 32'(bus.error_unexpected_rx_o), 32'd0);

    // Reset during ARGS abandons the command.
    bus.cmd_opcode_i     = 8'hC4;
    bus.cmd_args_i       = 24'h123456;
    bus.cmd_resp_count_i = 2'd1;
    bus.cmd_valid_i      = 1'b1;
    bus.tx_ready_i       = 1'b1;
    tick;
    bus.cmd_valid_i = 1'b0;
    check("mid opcode byte", 32'(bus.tx_data_o), 32'hC4);
    tick;
    check("mid first arg", 32'(bus.tx_data_o), 32'h12);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    bus.tx_ready_i = 1'b0;
    check("mid rst tx_valid", 32'(bus.tx_valid_o), 32'd0);
    check("mid rst cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    check("mid rst resp_valid", 32'(bus.resp_valid_o), 32'd0);
    tick;
    tick;
    check("mid rst no resp", 32'(bus.resp_valid_o), 32'd0);
    run_vec(vecs[4], 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
